// File: rtl/vendor_specific_info_frame_rx.sv
// Sink-side parser for HDMI Vendor-Specific InfoFrames: checksum check, HF-VSIF ALLM and
// Dolby low-latency decode, plus per-OUI frame timeouts that clear stale flags.
module vendor_specific_info_frame_rx #(
    parameter int unsigned TIMEOUT_FRAMES = 4
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        pkt_valid,
    input  logic        pkt_start,
    input  logic [7:0]  pkt_byte,
    input  logic        vsync,
    output logic        allm,
    output logic        dolby_ll,
    output logic        dolby_game,
    output logic [23:0] oui,
    output logic        pkt_done,
    output logic        pkt_error
);

    localparam logic [7:0]  VSIF_TYPE = 8'h81;
    localparam logic [23:0] OUI_HF    = 24'hC45DD8;
    localparam logic [23:0] OUI_DV    = 24'h00D046;
    localparam logic [4:0]  HB2_IDX   = 5'd2;
    localparam logic [4:0]  LAST_IDX  = 5'd27;
    localparam logic [4:0]  MAX_LEN   = 5'd27;
    localparam logic [7:0]  TMO       = 8'(TIMEOUT_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_BODY  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    function automatic logic [7:0] csum_acc(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  idx_r, idx_s;
    logic [7:0]  sum_r, sum_s;
    logic        drop_r, drop_s;
    logic [4:0]  len_r, len_s;
    logic [7:0]  pb1_r, pb1_s;
    logic [7:0]  pb2_r, pb2_s;
    logic [7:0]  pb3_r, pb3_s;
    logic        pb4_ll_r, pb4_ll_s;
    logic        pb5_allm_r, pb5_allm_s;
    logic        pb5_game_r, pb5_game_s;

    logic        vsync_r;
    logic [7:0]  hf_cnt_r, hf_cnt_s;
    logic [7:0]  dv_cnt_r, dv_cnt_s;

    logic        start_s;
    logic        in_check_s;
    logic        len_bad_s;
    logic        sum_ok_s;
    logic [23:0] rx_oui_s;
    logic        commit_s;
    logic        reject_s;
    logic        commit_hf_s;
    logic        commit_dv_s;
    logic        vsync_rise_s;

    logic        allm_s;
    logic        dolby_ll_s;
    logic        dolby_game_s;
    logic [23:0] oui_s;

    // Packet parser state and latched fields.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= 5'd0;
            sum_r      <= 8'd0;
            drop_r     <= 1'b0;
            len_r      <= 5'd0;
            pb1_r      <= 8'd0;
            pb2_r      <= 8'd0;
            pb3_r      <= 8'd0;
            pb4_ll_r   <= 1'b0;
            pb5_allm_r <= 1'b0;
            pb5_game_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            sum_r      <= sum_s;
            drop_r     <= drop_s;
            len_r      <= len_s;
            pb1_r      <= pb1_s;
            pb2_r      <= pb2_s;
            pb3_r      <= pb3_s;
            pb4_ll_r   <= pb4_ll_s;
            pb5_allm_r <= pb5_allm_s;
            pb5_game_r <= pb5_game_s;
        end
    end

    // Parser next-state: a start byte always restarts at HB0, even in CHECK.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        sum_s      = sum_r;
        drop_s     = drop_r;
        len_s      = len_r;
        pb1_s      = pb1_r;
        pb2_s      = pb2_r;
        pb3_s      = pb3_r;
        pb4_ll_s   = pb4_ll_r;
        pb5_allm_s = pb5_allm_r;
        pb5_game_s = pb5_game_r;
        start_s    = pkt_valid & pkt_start;

        if (start_s) begin
            state_s = ST_HDR;
            idx_s   = 5'd1;
            sum_s   = pkt_byte;
            drop_s  = (pkt_byte != VSIF_TYPE);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_HDR: begin
                    if (pkt_valid) begin
                        sum_s = csum_acc(sum_r, pkt_byte);
                        if (idx_r == HB2_IDX) begin
                            len_s   = pkt_byte[4:0];
                            idx_s   = 5'd0;
                            state_s = ST_BODY;
                        end else begin
                            idx_s = idx_r + 5'd1;
                        end
                    end else begin
                        state_s = ST_HDR;
                    end
                end
                ST_BODY: begin
                    if (pkt_valid) begin
                        // Bytes past PB[L] are consumed but stay out of the checksum.
                        if (idx_r <= len_r) begin
                            sum_s = csum_acc(sum_r, pkt_byte);
                        end else begin
                            sum_s = sum_r;
                        end
                        case (idx_r)
                            5'd1:    pb1_s = pkt_byte;
                            5'd2:    pb2_s = pkt_byte;
                            5'd3:    pb3_s = pkt_byte;
                            5'd4:    pb4_ll_s = pkt_byte[0];
                            5'd5: begin
                                pb5_allm_s = pkt_byte[1];
                                pb5_game_s = pkt_byte[5];
                            end
                            default: pb1_s = pb1_r;
                        endcase
                        if (idx_r == LAST_IDX) begin
                            state_s = ST_CHECK;
                        end else begin
                            idx_s = idx_r + 5'd1;
                        end
                    end else begin
                        state_s = ST_BODY;
                    end
                end
                ST_CHECK: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Verdict for the packet sitting in CHECK.
    always_comb begin
        in_check_s   = (state_r == ST_CHECK);
        len_bad_s    = (len_r > MAX_LEN);
        sum_ok_s     = (sum_r == 8'h00);
        rx_oui_s     = {pb3_r, pb2_r, pb1_r};
        commit_s     = in_check_s & ~drop_r & ~len_bad_s & sum_ok_s;
        reject_s     = in_check_s & ~drop_r & (len_bad_s | ~sum_ok_s);
        commit_hf_s  = commit_s & (rx_oui_s == OUI_HF);
        commit_dv_s  = commit_s & (rx_oui_s == OUI_DV);
        vsync_rise_s = vsync & ~vsync_r;
    end

    // Flag and timeout next-values; a commit takes priority over a vsync edge.
    always_comb begin
        allm_s       = allm;
        dolby_ll_s   = dolby_ll;
        dolby_game_s = dolby_game;
        hf_cnt_s     = hf_cnt_r;
        dv_cnt_s     = dv_cnt_r;

        if (commit_s) begin
            oui_s = rx_oui_s;
        end else begin
            oui_s = oui;
        end

        if (commit_hf_s) begin
            allm_s   = pb5_allm_r;
            hf_cnt_s = 8'd0;
        end else if (vsync_rise_s && (hf_cnt_r < TMO)) begin
            hf_cnt_s = hf_cnt_r + 8'd1;
            if (hf_cnt_s == TMO) begin
                allm_s = 1'b0;
            end else begin
                allm_s = allm;
            end
        end else begin
            hf_cnt_s = hf_cnt_r;
        end

        if (commit_dv_s) begin
            dolby_ll_s   = pb4_ll_r;
            dolby_game_s = pb5_game_r;
            dv_cnt_s     = 8'd0;
        end else if (vsync_rise_s && (dv_cnt_r < TMO)) begin
            dv_cnt_s = dv_cnt_r + 8'd1;
            if (dv_cnt_s == TMO) begin
                dolby_ll_s   = 1'b0;
                dolby_game_s = 1'b0;
            end else begin
                dolby_ll_s   = dolby_ll;
                dolby_game_s = dolby_game;
            end
        end else begin
            dv_cnt_s = dv_cnt_r;
        end
    end

    // Registered outputs, pulses and timeout counters.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            allm       <= 1'b0;
            dolby_ll   <= 1'b0;
            dolby_game <= 1'b0;
            oui        <= 24'd0;
            pkt_done   <= 1'b0;
            pkt_error  <= 1'b0;
            vsync_r    <= 1'b0;
            hf_cnt_r   <= 8'd0;
            dv_cnt_r   <= 8'd0;
        end else begin
            allm       <= allm_s;
            dolby_ll   <= dolby_ll_s;
            dolby_game <= dolby_game_s;
            oui        <= oui_s;
            pkt_done   <= commit_s;
            pkt_error  <= reject_s;
            vsync_r    <= vsync;
            hf_cnt_r   <= hf_cnt_s;
            dv_cnt_r   <= dv_cnt_s;
        end
    end

endmodule

// File: tb/tb_vendor_specific_info_frame_rx.sv
// Directed bench for vendor_specific_info_frame_rx: expected commits/rejects are queued by the
// stimulus thread and a negedge monitor pops and compares each pkt_done/pkt_error pulse.
module tb_vendor_specific_info_frame_rx;

    logic        clk;
    logic        reset_n;
    logic        pkt_valid;
    logic        pkt_start;
    logic [7:0]  pkt_byte;
    logic        vsync;
    logic        allm;
    logic        dolby_ll;
    logic        dolby_game;
    logic [23:0] oui;
    logic        pkt_done;
    logic        pkt_error;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic        err;
        logic        a;
        logic        l;
        logic        g;
        logic [23:0] o;
        int          cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pkt[0:30];

    vendor_specific_info_frame_rx #(.TIMEOUT_FRAMES(4)) dut (
        .clk_pixel (clk),
        .reset_n   (reset_n),
        .pkt_valid (pkt_valid),
        .pkt_start (pkt_start),
        .pkt_byte  (pkt_byte),
        .vsync     (vsync),
        .allm      (allm),
        .dolby_ll  (dolby_ll),
        .dolby_game(dolby_game),
        .oui       (oui),
        .pkt_done  (pkt_done),
        .pkt_error (pkt_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every pulse must match the oldest queued expectation, including its latency.
    always @(negedge clk) begin
        if (pkt_done || pkt_error) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got done=%0d error=%0d at cycle %0d, required no pulse",
                         pkt_done, pkt_error, cyc);
            end else begin
                exp_t e;
                logic [28:0] got;
                logic [28:0] want;
                e    = exp_q.pop_front();
                got  = {pkt_done, pkt_error, allm, dolby_ll, dolby_game, oui};
                want = {~e.err, e.err, e.a, e.l, e.g, e.o};
                if (got !== want) begin
                    n_errors++;
                    $display("FAIL pulse_fields: got {done,err,allm,ll,game,oui}=%h, required %h", got, want);
                end
                n_checks++;
                if (cyc != e.cyc) begin
                    n_errors++;
                    $display("FAIL pulse_latency: got cycle %0d, required cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    task automatic make_pkt(input logic [7:0] hb0, input logic [7:0] hb1, input logic [7:0] hb2,
                            input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                            input logic [7:0] p6, input logic [7:0] p7);
        for (int i = 0; i < 31; i++) pkt[i] = 8'h00;
        pkt[0] = hb0; pkt[1] = hb1; pkt[2] = hb2;
        pkt[3] = p0;  pkt[4] = p1;  pkt[5] = p2;  pkt[6] = p3;
        pkt[7] = p4;  pkt[8] = p5;  pkt[9] = p6;  pkt[10] = p7;
    endtask

    task automatic send_byte(input logic s, input logic [7:0] b);
        pkt_valid = 1'b1;
        pkt_start = s;
        pkt_byte  = b;
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        pkt_start = 1'b0;
        pkt_byte  = 8'h00;
    endtask

    task automatic send_pkt(input int first, input int last, input bit with_gap);
        for (int i = first; i <= last; i++) begin
            send_byte(i == 0, pkt[i]);
            if (with_gap && (i % 7 == 3) && (i != last)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Called right after the last byte: pulse is seen at the negedge following the next edge.
    task automatic push_exp(input logic err, input logic a, input logic l, input logic g,
                            input logic [23:0] o);
        exp_t e;
        e.err = err; e.a = a; e.l = l; e.g = g; e.o = o;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        @(posedge clk);
        #1;
        vsync = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_allm"}, {23'd0, allm}, 24'd0);
        chk({tag, "_dolby_ll"}, {23'd0, dolby_ll}, 24'd0);
        chk({tag, "_dolby_game"}, {23'd0, dolby_game}, 24'd0);
        chk({tag, "_oui"}, oui, 24'd0);
        chk({tag, "_pkt_done"}, {23'd0, pkt_done}, 24'd0);
        chk({tag, "_pkt_error"}, {23'd0, pkt_error}, 24'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        pkt_valid = 1'b0;
        pkt_start = 1'b0;
        pkt_byte  = 8'h00;
        vsync     = 1'b0;
        idle(3);
        chk_all_zero("reset");
        reset_n = 1'b1;
        idle(2);

        // HF-VSIF, L=5: PB7=0x12 lies outside the checksum range.
        make_pkt(8'h81, 8'h01, 8'h05, 8'h7d, 8'hd8, 8'h5d, 8'hc4, 8'h01, 8'h02, 8'h00, 8'h12);
        send_pkt(0, 30, 1'b0);
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, 24'hC45DD8);
        idle(4);

        // Dolby VSIF, L=27; PB0=0x2a makes the byte sum wrap to zero. Sent with gaps.
        make_pkt(8'h81, 8'h01, 8'h1b, 8'h2a, 8'h46, 8'hd0, 8'h00, 8'h03, 8'h20, 8'h00, 8'h00);
        send_pkt(0, 30, 1'b1);
        push_exp(1'b0, 1'b1, 1'b1, 1'b1, 24'h00D046);
        idle(4);

        // Bad checksum, then L=28: both rejected, flags and oui untouched.
        make_pkt(8'h81, 8'h01, 8'h05, 8'h7e, 8'hd8, 8'h5d, 8'hc4, 8'h01, 8'h02, 8'h00, 8'h12);
        send_pkt(0, 30, 1'b0);
        push_exp(1'b1, 1'b1, 1'b1, 1'b1, 24'h00D046);
        idle(3);
        make_pkt(8'h81, 8'h01, 8'h1c, 8'h7d, 8'hd8, 8'h5d, 8'hc4, 8'h01, 8'h02, 8'h00, 8'h12);
        send_pkt(0, 30, 1'b0);
        push_exp(1'b1, 1'b1, 1'b1, 1'b1, 24'h00D046);
        idle(3);

        // Valid VSIF with an unrelated OUI: only oui moves.
        make_pkt(8'h81, 8'h01, 8'h05, 8'h6a, 8'h03, 8'h0c, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send_pkt(0, 30, 1'b0);
        push_exp(1'b0, 1'b1, 1'b1, 1'b1, 24'h000C03);
        idle(4);

        // Timeout: flags survive three edges and clear on the fourth.
        for (int k = 1; k <= 4; k++) begin
            vsync_pulse();
            chk($sformatf("timeout_allm_edge%0d", k), {23'd0, allm}, {23'd0, (k < 4)});
            chk($sformatf("timeout_ll_edge%0d", k), {23'd0, dolby_ll}, {23'd0, (k < 4)});
            chk($sformatf("timeout_game_edge%0d", k), {23'd0, dolby_game}, {23'd0, (k < 4)});
        end

        // Commit lands on the same edge as a vsync rise: commit wins and restarts the count.
        make_pkt(8'h81, 8'h01, 8'h05, 8'h7d, 8'hd8, 8'h5d, 8'hc4, 8'h01, 8'h02, 8'h00, 8'h12);
        send_pkt(0, 30, 1'b0);
        vsync = 1'b1;
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, 24'hC45DD8);
        @(posedge clk);
        #1;
        vsync = 1'b0;
        idle(1);
        chk("coincident_allm", {23'd0, allm}, 24'd1);
        for (int k = 1; k <= 4; k++) begin
            vsync_pulse();
            chk($sformatf("retimeout_allm_edge%0d", k), {23'd0, allm}, {23'd0, (k < 4)});
        end

        // Restart at PB10, then a complete packet: exactly one commit.
        send_pkt(0, 12, 1'b0);
        send_pkt(0, 30, 1'b0);
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, 24'hC45DD8);
        idle(4);

        // Back-to-back: second HB0 arrives during the first packet's CHECK cycle.
        make_pkt(8'h81, 8'h01, 8'h1b, 8'h2a, 8'h46, 8'hd0, 8'h00, 8'h03, 8'h20, 8'h00, 8'h00);
        send_pkt(0, 30, 1'b0);
        push_exp(1'b0, 1'b1, 1'b1, 1'b1, 24'h00D046);
        make_pkt(8'h81, 8'h01, 8'h05, 8'h7d, 8'hd8, 8'h5d, 8'hc4, 8'h01, 8'h02, 8'h00, 8'h12);
        send_pkt(0, 30, 1'b0);
        push_exp(1'b0, 1'b1, 1'b1, 1'b1, 24'hC45DD8);
        idle(4);

        // Wrong type with a bad checksum: dropped silently.
        make_pkt(8'h82, 8'h01, 8'h05, 8'h7d, 8'hd8, 8'h5d, 8'hc4, 8'h01, 8'h02, 8'h00, 8'h12);
        send_pkt(0, 30, 1'b0);
        idle(5);
        chk("drop_oui", oui, 24'hC45DD8);

        // Reset mid-BODY; the tail without pkt_start is ignored, then a full packet commits once.
        make_pkt(8'h81, 8'h01, 8'h1b, 8'h2a, 8'h46, 8'hd0, 8'h00, 8'h03, 8'h20, 8'h00, 8'h00);
        send_pkt(0, 10, 1'b0);
        reset_n = 1'b0;
        idle(1);
        chk_all_zero("midreset");
        idle(1);
        reset_n = 1'b1;
        send_pkt(11, 30, 1'b0);
        idle(4);
        chk("after_tail_oui", oui, 24'd0);
        make_pkt(8'h81, 8'h01, 8'h05, 8'h7d, 8'hd8, 8'h5d, 8'hc4, 8'h01, 8'h02, 8'h00, 8'h12);
        send_pkt(0, 30, 1'b0);
        push_exp(1'b0, 1'b1, 1'b0, 1'b0, 24'hC45DD8);
        idle(10);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_pulses: got %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
